// File: rtl/sc_nido_detector_pkg.sv
// Shared definitions for the nest detector: FSM encoding, nest count and
// the column-to-nest decode helper.
package sc_nido_detector_pkg;

  // 3-bit state encoding, also visible on the debug state output.
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_EVAL_ENC    = 3'd1;
  localparam logic [2:0] ST_SCORE_ENC   = 3'd2;
  localparam logic [2:0] ST_DEATH_ENC   = 3'd3;
  localparam logic [2:0] ST_RESPAWN_ENC = 3'd4;

  // Number of nests in the nest row; one bitmap bit per nest.
  localparam int unsigned NUM_NIDOS = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_EVAL    = ST_EVAL_ENC,
    ST_SCORE   = ST_SCORE_ENC,
    ST_DEATH   = ST_DEATH_ENC,
    ST_RESPAWN = ST_RESPAWN_ENC
  } nido_state_e;

  // One-hot nest mask for a column: bit0 = nest A, bit1 = nest B,
  // all zero when the column is not a nest column.
  function automatic logic [NUM_NIDOS-1:0] nest_onehot(
    input logic [2:0] col,
    input logic [2:0] col_a,
    input logic [2:0] col_b
  );
    logic [NUM_NIDOS-1:0] mask;
    mask    = '0;
    mask[0] = (col == col_a);
    mask[1] = (col == col_b);
    return mask;
  endfunction

endpackage

// File: rtl/sc_nido_detector_respawn_timer.sv
// Respawn hold timer: loads a cycle count, counts down while enabled and
// flags the final cycle of the hold so the FSM can leave on that edge.
module SC_RESPAWN_TIMER #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load has priority, otherwise decrement while enabled,
  // saturating at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register, cleared by asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 is the last hold cycle; 0 is treated the same so a zero
  // load can never wedge the FSM.
  always_comb begin
    done_o = (cnt_q == ONE) || (cnt_q == '0);
  end

endmodule

// File: rtl/sc_nido_detector.sv
// Nest detector for the frog game: watches player moves into the nest row,
// scores free nests, kills the player on occupied/non-nest columns, then
// holds a respawn interval before accepting the next move.
//
// Move protocol: NidoDet_move_InLow is a one-cycle active-low strobe with no
// back-pressure. It is accepted only when the FSM is IDLE (busy low) and the
// row equals the nest row; strobes seen while busy are dropped, not queued.
module sc_nido_detector
  import sc_nido_detector_pkg::*;
#(
  parameter logic [3:0] NIDO_FILA      = 4'd0,
  parameter logic [2:0] NIDO_COL_A     = 3'd1,
  parameter logic [2:0] NIDO_COL_B     = 3'd5,
  parameter logic [7:0] RESPAWN_CYCLES = 8'd50
) (
  input  logic       NidoDet_CLOCK_50,
  input  logic       NidoDet_RESET_InLow,
  input  logic       NidoDet_clear_InLow,
  input  logic       NidoDet_move_InLow,
  input  logic [3:0] NidoDet_fila_InBUS,
  input  logic [2:0] NidoDet_col_InBUS,
  output logic       NidoDet_nido_alcanzado_OutLow,
  output logic       NidoDet_perder_vida_OutLow,
  output logic       NidoDet_respawn_OutLow,
  output logic [1:0] NidoDet_nidos_OutBUS,
  output logic       NidoDet_busy_OutHigh,
  output logic [2:0] NidoDet_state_OutBUS
);

  nido_state_e          state_q;
  nido_state_e          state_d;
  logic [3:0]           fila_q;
  logic [3:0]           fila_d;
  logic [2:0]           col_q;
  logic [2:0]           col_d;
  logic [NUM_NIDOS-1:0] nidos_q;
  logic [NUM_NIDOS-1:0] nidos_d;

  logic                 move_accept;
  logic [NUM_NIDOS-1:0] hit_mask;
  logic                 nest_free;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_done;

  // A move is taken only from IDLE and only when it lands in the nest row.
  always_comb begin
    move_accept = (state_q == ST_IDLE) && !NidoDet_move_InLow &&
                  (NidoDet_fila_InBUS == NIDO_FILA);
  end

  // Decode the latched position into the nest it targets and whether that
  // nest is still empty.
  always_comb begin
    hit_mask  = nest_onehot(col_q, NIDO_COL_A, NIDO_COL_B);
    if (fila_q != NIDO_FILA) begin
      hit_mask = '0;
    end
    nest_free = |(hit_mask & ~nidos_q);
  end

  // Position capture happens on the accepting edge and is then held
  // stable for the rest of the sequence.
  always_comb begin
    fila_d = fila_q;
    col_d  = col_q;
    if (move_accept) begin
      fila_d = NidoDet_fila_InBUS;
      col_d  = NidoDet_col_InBUS;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (move_accept) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d = nest_free ? ST_SCORE : ST_DEATH;
      end
      ST_SCORE: begin
        state_d = ST_RESPAWN;
      end
      ST_DEATH: begin
        state_d = ST_RESPAWN;
      end
      ST_RESPAWN: begin
        if (timer_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Nest bitmap: the scored nest is set as SCORE exits; a clear strobe
  // overrides everything, including a simultaneous set.
  always_comb begin
    nidos_d = nidos_q;
    if (state_q == ST_SCORE) begin
      nidos_d = nidos_q | hit_mask;
    end
    if (!NidoDet_clear_InLow) begin
      nidos_d = '0;
    end
  end

  // State, latched position and bitmap registers.
  always_ff @(posedge NidoDet_CLOCK_50 or negedge NidoDet_RESET_InLow) begin
    if (!NidoDet_RESET_InLow) begin
      state_q <= ST_IDLE;
      fila_q  <= '0;
      col_q   <= '0;
      nidos_q <= '0;
    end else begin
      state_q <= state_d;
      fila_q  <= fila_d;
      col_q   <= col_d;
      nidos_q <= nidos_d;
    end
  end

  // The timer is loaded while in the one-cycle pulse states so it holds
  // the full count on the first RESPAWN cycle, then counts down there.
  always_comb begin
    timer_load = (state_q == ST_SCORE) || (state_q == ST_DEATH);
    timer_en   = (state_q == ST_RESPAWN);
  end

  SC_RESPAWN_TIMER #(
    .W(8)
  ) u_respawn_timer (
    .clk_i      (NidoDet_CLOCK_50),
    .rst_ni     (NidoDet_RESET_InLow),
    .load_i     (timer_load),
    .load_val_i (RESPAWN_CYCLES),
    .en_i       (timer_en),
    .done_o     (timer_done)
  );

  // Moore outputs decoded from the state and bitmap registers only.
  always_comb begin
    NidoDet_nido_alcanzado_OutLow = (state_q != ST_SCORE);
    NidoDet_perder_vida_OutLow    = (state_q != ST_DEATH);
    NidoDet_respawn_OutLow        = (state_q != ST_RESPAWN);
    NidoDet_busy_OutHigh          = (state_q != ST_IDLE);
    NidoDet_nidos_OutBUS          = nidos_q;
    NidoDet_state_OutBUS          = state_q;
  end

endmodule

// File: doc/sc_nido_detector.md
SC_NIDO_DETECTOR -- requirements
Module: SC_NIDO_DETECTOR

Interface
REQ-001 The block SHALL have one clock, NidoDet_CLOCK_50; reset NidoDet_RESET_InLow is asynchronous and active-low.
REQ-002 Parameter NIDO_FILA, default 4'd0, SHALL be the row index of the nest row (top row).
REQ-003 Parameter NIDO_COL_A, default 3'd1, SHALL be the column of nest 0.
REQ-004 Parameter NIDO_COL_B, default 3'd5, SHALL be the column of nest 1.
REQ-005 Parameter RESPAWN_CYCLES, default 8'd50, SHALL be the respawn hold length in clocks (legal range 1..255).
REQ-006 Port NidoDet_CLOCK_50  in  1  system clock.
REQ-007 Port NidoDet_RESET_InLow  in  1  async reset, active-low.
REQ-008 Port NidoDet_clear_InLow  in  1  sync clear of the nest bitmap (new level), active-low.
REQ-009 Port NidoDet_move_InLow  in  1  one-cycle strobe, active-low: player position updated.
REQ-010 Port NidoDet_fila_InBUS  in  4  player row.
REQ-011 Port NidoDet_col_InBUS  in  3  player column.
REQ-012 Port NidoDet_nido_alcanzado_OutLow  out  1  one-cycle low pulse: free nest reached (drives the nest counter increment input).
REQ-013 Port NidoDet_perder_vida_OutLow  out  1  one-cycle low pulse: occupied nest or non-nest column in nest row.
REQ-014 Port NidoDet_respawn_OutLow  out  1  held low during the respawn interval.
REQ-015 Port NidoDet_nidos_OutBUS  out  2  nest occupancy bitmap, bit0 = nest 0.
REQ-016 Port NidoDet_busy_OutHigh  out  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EVAL, SCORE, DEATH, RESPAWN; outputs are Moore (decoded from state register and bitmap register only).
REQ-018 IDLE -> EVAL when move_InLow==0 and fila_InBUS==NIDO_FILA at a clock edge; fila/col SHALL be latched at that edge.
REQ-019 move_InLow==0 with fila!=NIDO_FILA SHALL leave the FSM in IDLE with no output change.
REQ-020 EVAL (one cycle) -> SCORE if latched col matches a nest whose bitmap bit is 0; otherwise -> DEATH.
REQ-021 SCORE (one cycle): nido_alcanzado_OutLow=0; matching bitmap bit set at exit edge; -> RESPAWN.
REQ-022 DEATH (one cycle): perder_vida_OutLow=0; bitmap unchanged; -> RESPAWN.
REQ-023 Latency: pulse SHALL be visible in the cycle starting two edges after the edge sampling the move strobe.
REQ-024 RESPAWN: respawn_OutLow=0 for exactly RESPAWN_CYCLES cycles, then -> IDLE.
REQ-025 move_InLow strobes in any state other than IDLE SHALL be ignored (not queued).
REQ-026 Bitmap full (2'b11): any nest-row arrival SHALL go to DEATH.
REQ-027 clear_InLow==0 SHALL zero the bitmap at the next edge in any state; on a simultaneous SCORE set, clear wins; the FSM and any pending pulse are unaffected.
REQ-028 NIDO_COL_A==NIDO_COL_B is illegal; behaviour is unspecified.

Reset
REQ-029 Reset low SHALL force immediately: state IDLE, bitmap 2'b00, respawn counter 0, latched position 0.
REQ-030 Reset values: nido_alcanzado_OutLow=1, perder_vida_OutLow=1, respawn_OutLow=1, busy_OutHigh=0, nidos_OutBUS=2'b00.
REQ-031 Reset asserted mid-SCORE/DEATH/RESPAWN SHALL abort the sequence; no pulse is emitted after release until a new qualifying move.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (3-bit localparams for the five states) and the nest count constant (2).
REQ-033 The respawn down-counter SHALL be a sub-module SC_RESPAWN_TIMER (load, count-down, done flag), instantiated once.

Verification
REQ-034 Reset, move at row 0 col 1 -> EVAL, SCORE: nido_alcanzado low exactly 1 cycle, 2 edges after strobe; nidos=2'b01; respawn low 50 cycles; busy then 0.
REQ-035 Bitmap 2'b01, move row 0 col 1 -> perder_vida low 1 cycle, nido_alcanzado stays 1, nidos stays 2'b01.
REQ-036 Move row 0 col 3 -> DEATH pulse; move row 7 col 1 -> no state change, busy stays 0.
REQ-037 Strobes every cycle during RESPAWN -> no additional pulses; IDLE reached after exactly 50 respawn cycles.
REQ-038 Col 5 then col 1 -> nidos=2'b11; a further col 5 -> DEATH; clear_InLow low coincident with a SCORE cycle -> pulse seen, nidos=2'b00.
REQ-039 Reset asserted during RESPAWN cycle 10 -> all outputs at reset values immediately, no pulse after release.
